// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scheduler and its mul/div wait timer.
package hazard_pkg;

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StMdWait = 1'b1
    } hz_state_e;

    localparam int unsigned MD_LAT_DEF  = 4;
    localparam int unsigned MD_CNT_W    = 4;
    localparam int unsigned STALL_CNT_W = 16;
    localparam logic [4:0]  REG_ZERO    = 5'd0;

endpackage

// File: rtl/hazard_sched_if.sv
// Pipeline <-> hazard scheduler signal bundle; master is the pipeline, slave the scheduler.
interface hazard_sched_if;
    import hazard_pkg::*;

    logic [4:0]             ID_Rs;
    logic [4:0]             ID_Rt;
    logic [1:0]             ID_PCSrc;
    logic                   ID_MDStart;
    logic                   EX_MemRead;
    logic [4:0]             EX_Rt;
    logic                   EX_BranchTaken;
    logic                   Stall;
    logic                   PCWrite;
    logic                   IFID_Write;
    logic                   IFID_Flush;
    logic                   IDEX_Flush;
    logic                   MD_Busy;
    logic [STALL_CNT_W-1:0] StallCnt;

    modport master (
        output ID_Rs, ID_Rt, ID_PCSrc, ID_MDStart, EX_MemRead, EX_Rt, EX_BranchTaken,
        input  Stall, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MD_Busy, StallCnt
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_PCSrc, ID_MDStart, EX_MemRead, EX_Rt, EX_BranchTaken,
        output Stall, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, MD_Busy, StallCnt
    );

endinterface

// File: rtl/md_timer.sv
// Loadable down-counter timing the mul/div wait; done flags a zero count.
module md_timer
    import hazard_pkg::*;
#(
    parameter int unsigned Width = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    input  logic             i_count,
    output logic             o_done
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use stall, branch/jump flushes, saturating stall counter.
// Define MULDIV_STALL_EN to add the multi-cycle mul/div wait (MDWAIT state + md_timer).
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LAT = MD_LAT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    hazard_sched_if.slave  bus
);

    logic                   w_load_use;
    logic                   w_stall;
    logic                   w_pc_write;
    logic                   w_ifid_write;
    logic                   w_ifid_flush;
    logic                   w_idex_flush;
    logic                   w_md_busy;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_load_use = bus.EX_MemRead && (bus.EX_Rt != REG_ZERO) &&
                        ((bus.EX_Rt == bus.ID_Rs) || (bus.EX_Rt == bus.ID_Rt));

`ifdef MULDIV_STALL_EN
    // First stall cycle is spent in RUN, so the timer covers the remaining MD_LAT-1.
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 2);

    hz_state_e r_state;
    hz_state_e w_state_nxt;
    logic      w_md_load;
    logic      w_md_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= StRun;
        else        r_state <= w_state_nxt;
    end

    md_timer #(
        .Width (MD_CNT_W)
    ) u_md_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_md_load),
        .i_load_val (MD_LOAD),
        .i_count    (r_state == StMdWait),
        .o_done     (w_md_done)
    );
`else
    logic w_unused;
    assign w_unused = bus.ID_MDStart;
`endif

    always_comb begin
        w_stall      = 1'b0;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_md_busy    = 1'b0;
`ifdef MULDIV_STALL_EN
        w_state_nxt  = r_state;
        w_md_load    = 1'b0;
`endif
        if (!reset) begin
            // Outputs forced idle while reset is held, whatever the inputs say.
        end
`ifdef MULDIV_STALL_EN
        else if (r_state == StMdWait) begin
            w_stall      = 1'b1;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_md_busy    = 1'b1;
            if (w_md_done) w_state_nxt = StRun;
        end
`endif
        else if (bus.EX_BranchTaken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_load_use) begin
            w_stall      = 1'b1;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
        end
`ifdef MULDIV_STALL_EN
        else if (bus.ID_MDStart) begin
            w_stall      = 1'b1;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_md_load    = 1'b1;
            w_state_nxt  = StMdWait;
        end
`endif
        else if (bus.ID_PCSrc != 2'b00) begin
            w_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.Stall      = w_stall;
    assign bus.PCWrite    = w_pc_write;
    assign bus.IFID_Write = w_ifid_write;
    assign bus.IFID_Flush = w_ifid_flush;
    assign bus.IDEX_Flush = w_idex_flush;
    assign bus.MD_Busy    = w_md_busy;
    assign bus.StallCnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed literal scenarios, then random traffic
// checked every cycle against a remaining-wait-cycles reference model.
module tb_hazard_sched;
    import hazard_pkg::*;

    localparam int unsigned MD_LAT = 4;
`ifdef MULDIV_STALL_EN
    localparam bit MdEn = 1'b1;
`else
    localparam bit MdEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   m_left = 0;   // remaining MDWAIT cycles after the issue cycle
    int   m_cnt  = 0;   // stall cycles seen since reset

    hazard_sched_if hif ();

    hazard_sched #(
        .MD_LAT (MD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_lu();
        return hif.EX_MemRead && (hif.EX_Rt != 5'd0) &&
               ((hif.EX_Rt == hif.ID_Rs) || (hif.EX_Rt == hif.ID_Rt));
    endfunction

    function automatic bit m_md_issue();
        return MdEn && reset && (m_left == 0) && !hif.EX_BranchTaken && !m_lu() &&
               hif.ID_MDStart;
    endfunction

    function automatic logic [21:0] model_out();
        logic s, pw, iw, ff, xf, b;
        s = 1'b0; pw = 1'b1; iw = 1'b1; ff = 1'b0; xf = 1'b0; b = 1'b0;
        if (!reset) begin
            s = 1'b0;
        end else if (m_left > 0) begin
            s = 1'b1; pw = 1'b0; iw = 1'b0; b = 1'b1;
        end else if (hif.EX_BranchTaken) begin
            ff = 1'b1; xf = 1'b1;
        end else if (m_lu() || m_md_issue()) begin
            s = 1'b1; pw = 1'b0; iw = 1'b0;
        end else if (hif.ID_PCSrc != 2'b00) begin
            ff = 1'b1;
        end
        return {s, pw, iw, ff, xf, b, 16'(m_cnt)};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_cnt  <= 0;
        end else begin
            if (model_out() >= 22'h200000 && m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (m_left > 0)        m_left <= m_left - 1;
            else if (m_md_issue()) m_left <= MD_LAT - 1;
        end
    end

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("cycle", 32'({hif.Stall, hif.PCWrite, hif.IFID_Write, hif.IFID_Flush,
                              hif.IDEX_Flush, hif.MD_Busy, hif.StallCnt}), 32'(model_out()));
        end
    end

    task automatic quiet();
        hif.ID_Rs = 5'd1; hif.ID_Rt = 5'd2; hif.ID_PCSrc = 2'b00; hif.ID_MDStart = 1'b0;
        hif.EX_MemRead = 1'b0; hif.EX_Rt = 5'd0; hif.EX_BranchTaken = 1'b0;
    endtask

    task automatic set_lu();
        quiet();
        hif.EX_MemRead = 1'b1; hif.EX_Rt = 5'd8; hif.ID_Rs = 5'd8; hif.ID_Rt = 5'd3;
    endtask

    int sc, bc;

    initial begin
        // Reset held with a load-use present: outputs must still be idle.
        set_lu();
        #2;
        chk("rst_outs", 32'({hif.Stall, hif.PCWrite, hif.IFID_Write, hif.IFID_Flush,
                             hif.IDEX_Flush, hif.MD_Busy}), 32'(6'b011000));
        chk("rst_cnt", 32'(hif.StallCnt), 32'd0);

        @(negedge clk); reset = 1'b1; chk_en = 1'b1; set_lu();
        #2 chk("lu_outs", 32'({hif.Stall, hif.PCWrite, hif.IFID_Write, hif.IFID_Flush,
                               hif.IDEX_Flush}), 32'(5'b10000));
        @(negedge clk); quiet();
        #2 chk("lu_cnt", 32'(hif.StallCnt), 32'd1);
        chk("lu_once", 32'(hif.Stall), 32'd0);

        @(negedge clk); quiet(); hif.EX_MemRead = 1'b1; hif.EX_Rt = 5'd0; hif.ID_Rs = 5'd0;
        #2 chk("r0_nostall", 32'({hif.Stall, hif.PCWrite}), 32'(2'b01));

        @(negedge clk); set_lu(); hif.EX_BranchTaken = 1'b1;
        #2 chk("br_prio", 32'({hif.Stall, hif.PCWrite, hif.IFID_Flush, hif.IDEX_Flush}),
               32'(4'b0111));

        @(negedge clk); quiet(); hif.ID_PCSrc = 2'b01;
        #2 chk("jmp", 32'({hif.IFID_Flush, hif.IDEX_Flush, hif.PCWrite, hif.Stall}),
               32'(4'b1010));
        chk("cnt_hold", 32'(hif.StallCnt), 32'd1);

        @(negedge clk); quiet(); hif.ID_MDStart = 1'b1;
        #2;
`ifdef MULDIV_STALL_EN
        sc = int'(hif.Stall);
        bc = int'(hif.MD_Busy);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); hif.ID_MDStart = 1'b0;
            #2;
            sc += int'(hif.Stall);
            bc += int'(hif.MD_Busy);
        end
        chk("md_stall_cycles", 32'(sc), 32'd4);
        chk("md_busy_cycles", 32'(bc), 32'd3);
        chk("md_cnt_total", 32'(hif.StallCnt), 32'd5);

        @(negedge clk); hif.ID_MDStart = 1'b1;
        @(negedge clk); hif.ID_MDStart = 1'b0;
        @(negedge clk);
        #2 chk("md_wait2_busy", 32'(hif.MD_Busy), 32'd1);
`else
        chk("md_ignored", 32'({hif.Stall, hif.MD_Busy, hif.PCWrite}), 32'(3'b001));
        @(negedge clk); hif.ID_MDStart = 1'b0;
        #2;
`endif
        reset = 1'b0;
        #1 chk("arst_outs", 32'({hif.Stall, hif.PCWrite, hif.IFID_Write, hif.MD_Busy}),
               32'(4'b0110));
        chk("arst_cnt", 32'(hif.StallCnt), 32'd0);
        @(negedge clk); reset = 1'b1;
        #2 chk("after_rst", 32'({hif.Stall, hif.MD_Busy, hif.PCWrite}), 32'(3'b001));

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = 1'b1;
            hif.ID_Rs          = 5'($urandom_range(0, 3));
            hif.ID_Rt          = 5'($urandom_range(0, 3));
            hif.EX_Rt          = 5'($urandom_range(0, 3));
            hif.EX_MemRead     = 1'($urandom_range(0, 1));
            hif.EX_BranchTaken = ($urandom_range(0, 7) == 0);
            hif.ID_PCSrc       = 2'($urandom_range(0, 3));
            hif.ID_MDStart     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #3 reset = 1'b0;
            end
        end
        @(negedge clk); reset = 1'b1; quiet();
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 The parameter MD_LAT SHALL default to 4 and give the total stall cycles per multiply/divide issue (legal range 2..16).
REQ-002 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  asynchronous active-low reset.
REQ-005 Port ID_Rs  input  5  rs field of the instruction in ID.
REQ-006 Port ID_Rt  input  5  rt field of the instruction in ID.
REQ-007 Port ID_PCSrc  input  2  PC source decoded in ID (nonzero means jump or jr/jalr).
REQ-008 Port ID_MDStart  input  1  the instruction in ID is a multi-cycle mul/div.
REQ-009 Port EX_MemRead  input  1  the instruction in EX is a load.
REQ-010 Port EX_Rt  input  5  destination rt of the instruction in EX.
REQ-011 Port EX_BranchTaken  input  1  the branch in EX resolved taken.
REQ-012 Port Stall  output  1  drives the Stall input of the decoder, forcing a bubble.
REQ-013 Port PCWrite  output  1  PC update enable.
REQ-014 Port IFID_Write  output  1  IF/ID register write enable.
REQ-015 Port IFID_Flush  output  1  clears IF/ID to a nop.
REQ-016 Port IDEX_Flush  output  1  clears ID/EX to a bubble.
REQ-017 Port MD_Busy  output  1  the mul/div wait is in progress.
REQ-018 Port StallCnt  output  16  saturating count of cycles with Stall=1.

Function
REQ-019 The FSM SHALL have states RUN and MDWAIT, plus a 4-bit down-counter md_cnt.
REQ-020 Load-use is defined as EX_MemRead and EX_Rt!=0 and (EX_Rt==ID_Rs or EX_Rt==ID_Rt).
REQ-021 In RUN, a load-use SHALL give Stall=1, PCWrite=0 and IFID_Write=0 in the same cycle (combinational), for exactly one cycle per occurrence.
REQ-022 EX_BranchTaken SHALL give IFID_Flush=1 and IDEX_Flush=1 in the same cycle and SHALL take priority over load-use and ID_MDStart (Stall=0, PCWrite=1, no MDWAIT entry).
REQ-023 ID_PCSrc!=0 with no taken branch and no load-use SHALL give IFID_Flush=1 only.
REQ-024 ID_MDStart in RUN with no taken branch and no load-use SHALL give Stall=1, PCWrite=0, IFID_Write=0 and load md_cnt=MD_LAT-2, with the state moving to MDWAIT at the next edge.
REQ-025 In MDWAIT: Stall=1, PCWrite=0, IFID_Write=0 and MD_Busy=1; md_cnt SHALL decrement each cycle, and the FSM SHALL return to RUN on the edge where md_cnt==0. This gives exactly MD_LAT stall cycles in total.
REQ-026 Load-use with ID_MDStart at the same time SHALL serve load-use first; MDWAIT entry is re-evaluated next cycle.
REQ-027 Outside the conditions above, the outputs SHALL be Stall=0, PCWrite=1, IFID_Write=1 and both flushes 0.
REQ-028 StallCnt SHALL increment on every edge where Stall=1 and hold at 16'hFFFF.

Reset
REQ-029 On reset low, the FSM SHALL go to RUN with md_cnt=0 and StallCnt=0 immediately, independent of clk.
REQ-030 Reset asserted during MDWAIT SHALL abort the wait, with MD_Busy=0 at once.
REQ-031 During reset the outputs SHALL be Stall=0, PCWrite=1, IFID_Write=1, flushes 0 and MD_Busy=0.

Configuration
REQ-032 With the macro MULDIV_STALL_EN defined, REQ-024 through REQ-026 SHALL apply.
REQ-033 With MULDIV_STALL_EN undefined, ID_MDStart SHALL be ignored, MDWAIT and md_cnt SHALL be absent, and MD_Busy SHALL be tied to 0.

Structure
REQ-034 A shared package hazard_pkg SHALL hold the state encoding (RUN=0, MDWAIT=1), the MD_LAT default, the md_cnt width (4), the StallCnt width (16) and the constant REG_ZERO=5'd0.
REQ-035 The md_cnt countdown SHALL be the sub-module md_timer (load, count, done), instantiated only under MULDIV_STALL_EN.

Verification
REQ-036 Scenario: EX_MemRead=1, EX_Rt=8, ID_Rs=8 -> one cycle of Stall=1, PCWrite=0, IFID_Write=0, StallCnt=1.
REQ-037 Scenario: EX_MemRead=1, EX_Rt=0, ID_Rs=0 -> no stall.
REQ-038 Scenario: EX_BranchTaken=1 together with the load-use of REQ-036 -> IFID_Flush=IDEX_Flush=1, Stall=0.
REQ-039 Scenario: ID_PCSrc=2'b01 -> IFID_Flush=1, IDEX_Flush=0, PCWrite=1.
REQ-040 Scenario: MD_LAT=4, ID_MDStart pulse -> Stall=1 for exactly 4 cycles, MD_Busy=1 for the last 3, then RUN.
REQ-041 Scenario: reset low in the 2nd MDWAIT cycle -> Stall=0, MD_Busy=0, StallCnt=0 immediately, and RUN after release.
